// File: rtl/acc_bank_clr_load_pkg.sv
// Shared classifier definitions: readout FSM states and fixed-point helpers
// for saturation bounds and sign extension.
package acc_bank_clr_load_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_e;

    // Largest signed value representable in w bits, returned at 64 bits.
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    // Treats the low w bits of v as a signed number and sign-extends it to 64 bits.
    function automatic logic signed [63:0] sext(input logic [63:0] v, input int w);
        return $signed(v << (64 - w)) >>> (64 - w);
    endfunction

endpackage

// File: rtl/acc_bank_clr_load_if.sv
// Control, write and readout-stream signals of the accumulator bank.
interface acc_bank_clr_load_if #(
    parameter int N_CH  = 10,
    parameter int W_IN  = 20,
    parameter int W_ACC = 24
);
    localparam int CH_W = $clog2(N_CH);

    logic                    clr;
    logic                    load;
    logic                    acc;
    logic [CH_W-1:0]         ch_sel;
    logic signed [W_IN-1:0]  d;
    logic                    rd_start;
    logic                    out_valid;
    logic                    out_ready;
    logic [CH_W-1:0]         out_ch;
    logic signed [W_ACC-1:0] out_data;
    logic                    out_last;
    logic                    rd_done;
    logic                    busy;
    logic                    sat_any;

    modport master (
        output clr, load, acc, ch_sel, d, rd_start, out_ready,
        input  out_valid, out_ch, out_data, out_last, rd_done, busy, sat_any
    );

    modport slave (
        input  clr, load, acc, ch_sel, d, rd_start, out_ready,
        output out_valid, out_ch, out_data, out_last, rd_done, busy, sat_any
    );
endinterface

// File: rtl/acc_bank_clr_load_lane.sv
// One accumulator channel: clear > load > saturating accumulate > hold,
// with a sticky saturation flag.
module acc_lane
    import acc_bank_clr_load_pkg::*;
#(
    parameter int W_IN  = 20,
    parameter int W_ACC = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    load_en,
    input  logic                    acc_en,
    input  logic signed [W_IN-1:0]  d,
    output logic signed [W_ACC-1:0] value,
    output logic                    sat
);
    localparam logic signed [W_ACC-1:0] ACC_MAX = W_ACC'(sat_max(W_ACC));
    localparam logic signed [W_ACC-1:0] ACC_MIN = W_ACC'(sat_min(W_ACC));

    logic signed [W_ACC-1:0] d_ext;
    logic signed [W_ACC:0]   sum;

    assign d_ext = W_ACC'(sext(64'(d), W_IN));
    // One guard bit: overflow shows up as the top two bits disagreeing.
    assign sum   = {value[W_ACC-1], value} + {d_ext[W_ACC-1], d_ext};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            value <= '0;
            sat   <= 1'b0;
        end else if (load_en) begin
            value <= d_ext;
        end else if (acc_en) begin
            if (sum[W_ACC] != sum[W_ACC-1]) begin
                value <= sum[W_ACC] ? ACC_MIN : ACC_MAX;
                sat   <= 1'b1;
            end else begin
                value <= sum[W_ACC-1:0];
            end
        end
    end
endmodule

// File: rtl/acc_bank_clr_load.sv
// Bank of N_CH saturating accumulators with a valid/ready readout sequencer
// that streams every channel to the output stage.
//   state  | meaning
//   IDLE   | bank writable, no readout in progress
//   STREAM | bank frozen, presenting channel idx on the output stream
module acc_bank_clr_load
    import acc_bank_clr_load_pkg::*;
#(
    parameter int N_CH  = 10,
    parameter int W_IN  = 20,
    parameter int W_ACC = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    acc_bank_clr_load_if.slave  bus
);
    localparam int CH_W = $clog2(N_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    if (W_ACC < W_IN) begin : g_bad_width
        $error("acc_bank_clr_load: W_ACC must be >= W_IN");
    end

    rd_state_e               state, state_nxt;
    logic [CH_W-1:0]         idx, idx_nxt;
    logic                    rd_done_nxt;
    logic                    rd_done_q;
    logic [N_CH-1:0]         load_en, acc_en, sat;
    logic signed [W_ACC-1:0] bank [N_CH];
    logic                    wr_ok;

    // Writes are dropped while streaming and for out-of-range channels.
    assign wr_ok = (state == IDLE) && ({1'b0, bus.ch_sel} < (CH_W + 1)'(N_CH));

    always_comb begin
        load_en = '0;
        acc_en  = '0;
        for (int i = 0; i < N_CH; i++) begin
            load_en[i] = wr_ok && bus.load && (bus.ch_sel == CH_W'(i));
            acc_en[i]  = wr_ok && bus.acc  && (bus.ch_sel == CH_W'(i));
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        acc_lane #(
            .W_IN  (W_IN),
            .W_ACC (W_ACC)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (bus.clr),
            .load_en (load_en[g]),
            .acc_en  (acc_en[g]),
            .d       (bus.d),
            .value   (bank[g]),
            .sat     (sat[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            rd_done_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            rd_done_q <= rd_done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        rd_done_nxt = 1'b0;
        if (bus.clr) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rd_start) begin
                        state_nxt = STREAM;
                        idx_nxt   = '0;
                    end
                end
                STREAM: begin
                    if (bus.out_ready) begin
                        if (idx == LAST_CH) begin
                            state_nxt   = IDLE;
                            idx_nxt     = '0;
                            rd_done_nxt = 1'b1;
                        end else begin
                            idx_nxt = idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    // Output word depends only on registered idx and bank, never on out_ready.
    always_comb begin
        bus.out_valid = (state == STREAM);
        bus.busy      = (state == STREAM);
        bus.out_ch    = idx;
        bus.out_last  = (state == STREAM) && (idx == LAST_CH);
        bus.out_data  = (state == STREAM) ? bank[idx] : '0;
    end

    assign bus.rd_done = rd_done_q;
    assign bus.sat_any = |sat;
endmodule
